i2c_read_arbiter: RTL and testbench
===================================

Name: i2c_read_arbiter

Overview:
- Shares one I2C read engine (start/busy/done handshake, 2-byte read from a 7-bit slave address) among N_REQ independent requesters, e.g. several temperature-sensor pollers.
- Round-robin arbitration, one transaction at a time.
- Forwards the granted requester's address to the engine and returns the 16-bit result, tagged with the requester ID.
- A watchdog aborts transactions where the engine never signals completion.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester ID; must satisfy 2**ID_W >= N_REQ
- TIMEOUT_CYCLES, 20000, clk cycles allowed from eng_start to eng_done (400 us at 50 MHz)
- TO_W, 16, width of watchdog counter; must hold TIMEOUT_CYCLES

Ports:
- clk  in  1  system clock, 50 MHz; single clock domain
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester read request, level; hold until own rsp_valid
- req_addr  in  7*N_REQ  slave address of requester i at [7i+6:7i]
- gnt  out  N_REQ  one-hot grant, held for the whole transaction
- rsp_valid  out  1  one-cycle pulse, response fields valid
- rsp_id  out  ID_W  index of the requester being answered
- rsp_data  out  16  read data, MSB byte in [15:8]
- rsp_err  out  1  1 = slave NACK or watchdog timeout
- eng_start  out  1  one-cycle pulse launching an engine read
- eng_addr  out  7  slave address for the engine, stable from eng_start until done/abort
- eng_busy  in  1  engine transaction in progress
- eng_done  in  1  one-cycle pulse, engine finished
- eng_nack  in  1  address not acknowledged; valid only with eng_done
- eng_data  in  16  engine result; valid only with eng_done

Behaviour:
- Reset (rst=1 at a clk edge): every output goes to 0, state goes to IDLE and the RR pointer goes to 0.
  - Reset wins over any in-flight transaction; no response is generated.
  - The engine is not notified, so the next grant waits for eng_busy=0.
- The FSM is registered, with states IDLE, START, WAIT, RESP and RECOVER.
- IDLE:
  - Move to START when any req bit is 1 and eng_busy=0.
  - The winner is the first set req bit searching upward (with wrap) from index ptr.
  - Register gnt=onehot(winner), eng_addr=req_addr[winner], cur_id=winner, and set ptr=winner+1 mod N_REQ.
  - If eng_busy=1, stay in IDLE and issue no grant.
- START (exactly 1 cycle):
  - eng_start=1.
  - Clear the watchdog counter.
  - Go to WAIT.
- WAIT:
  - The counter increments every cycle.
  - If eng_done=1, latch rsp_data=eng_data, rsp_err=eng_nack and rsp_id=cur_id, then go to RESP.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1, latch rsp_data=0, rsp_err=1 and rsp_id=cur_id, then go to RESP with the abort flag set.
  - If eng_done and timeout occur in the same cycle, eng_done wins and no abort is flagged.
- RESP (exactly 1 cycle):
  - rsp_valid=1.
  - Go to RECOVER if the abort flag is set, else to IDLE.
  - gnt clears on exit from RESP.
- RECOVER:
  - gnt=0.
  - Wait for eng_busy=0, then go to IDLE.
  - eng_done pulses arriving in RECOVER or IDLE are ignored.
- Latency:
  - req sampled at edge t (engine idle): gnt and eng_start are high in cycle t+1.
  - eng_done at edge d: rsp_valid is high in cycle d+1.
  - The earliest next grant is in cycle d+3.
- A requester dropping req mid-transaction does not abort it: the transaction completes and the response is still emitted with that ID.
- A requester keeping req high after its rsp_valid is treated as a new request. Round robin guarantees every other pending requester is served first.
- rsp_id, rsp_data and rsp_err hold their values until the next rsp_valid.
- eng_addr holds its last value between transactions.
- req_addr is sampled only at grant; later changes do not affect the transaction in flight.
- The ptr increment wraps N_REQ-1 to 0.

Test Plan:
- Single request: req=0001, req_addr[6:0]=7'h48; engine returns done after 100 cycles with data 16'h1980, nack=0.
  - Required: gnt=0001 and eng_start pulse one cycle after req; eng_addr=7'h48.
  - Required: rsp_valid one cycle after done, with rsp_id=0, rsp_data=16'h1980, rsp_err=0.
- Full contention: req=1111 held throughout, each requester dropping req after its own rsp_valid; engine model returns data=16'h00A0+id.
  - Required: grant order 0,1,2,3.
  - Required: four rsp_valid pulses with matching id/data and no overlapping gnt.
- Fairness wrap: serve requester 2, then assert req=0101.
  - Required: requester 0 is granted next (search starts at index 3 and wraps).
- NACK: engine returns eng_done with eng_nack=1 and data=16'hFFFF.
  - Required: rsp_err=1, rsp_data=16'hFFFF, FSM back to IDLE.
- Timeout: engine never pulses done and holds eng_busy=1 for 30000 cycles.
  - Required: rsp_valid exactly TIMEOUT_CYCLES cycles after eng_start, with rsp_err=1 and rsp_data=0.
  - Required: no new eng_start until eng_busy falls, even with other requests pending.
- Reset mid-WAIT: assert rst for 1 cycle during a transaction while eng_busy=1.
  - Required: all outputs 0 the next cycle and no rsp_valid.
  - Required: a pending request is granted only after eng_busy=0.

Source files
------------

// File: rtl/i2c_read_arbiter_if.sv
// Bundle of the requester-side and engine-side signals of the shared I2C read
// engine. The arbiter connects through the slave modport. The requesters and
// the engine connect through the master modport.
//
// Handshake semantics:
//   req[i]       level. The requester raises it and holds it until its own
//                rsp_valid. A bit still high after that is a new request.
//   gnt          one-hot. Held from the grant until the response cycle.
//   rsp_valid    one-cycle pulse. rsp_id, rsp_data and rsp_err are valid with
//                it and hold their values until the next pulse.
//   eng_start    one-cycle pulse. eng_addr is stable from this pulse until
//                done or abort.
//   eng_busy     level. High while the engine is working.
//   eng_done     one-cycle pulse. eng_nack and eng_data are meaningful only
//                while eng_done is high.
interface i2c_read_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]   req;
  logic [7*N_REQ-1:0] req_addr;
  logic [N_REQ-1:0]   gnt;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic [15:0]        rsp_data;
  logic               rsp_err;
  logic               eng_start;
  logic [6:0]         eng_addr;
  logic               eng_busy;
  logic               eng_done;
  logic               eng_nack;
  logic [15:0]        eng_data;

  modport slave (
    input  req, req_addr, eng_busy, eng_done, eng_nack, eng_data,
    output gnt, rsp_valid, rsp_id, rsp_data, rsp_err, eng_start, eng_addr
  );

  modport master (
    output req, req_addr, eng_busy, eng_done, eng_nack, eng_data,
    input  gnt, rsp_valid, rsp_id, rsp_data, rsp_err, eng_start, eng_addr
  );
endinterface

// File: rtl/i2c_read_arbiter.sv
// Round-robin arbiter that shares one I2C 2-byte read engine among N_REQ
// requesters. It serves one transaction at a time. A watchdog aborts a read
// when the engine never reports completion.
module i2c_read_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int TO_W           = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  i2c_read_arbiter_if.slave    bus,
  output logic [2:0]           o_dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RESP    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_cur_id;
  logic [N_REQ-1:0]  r_gnt;
  logic [6:0]        r_eng_addr;
  logic [ID_W-1:0]   r_rsp_id;
  logic [15:0]       r_rsp_data;
  logic              r_rsp_err;
  logic              r_abort;
  logic [TO_W-1:0]   r_cnt;

  logic [ID_W-1:0]   w_winner;
  logic              w_any_req;
  logic              w_grant;
  logic [TO_W-1:0]   w_cnt_inc;
  logic              w_timeout;
  int                w_idx;

  // Round-robin search: the first set req bit at or above r_ptr, with wrap.
  // The loop runs downward, so the lowest offset from r_ptr is assigned last
  // and wins.
  always_comb begin
    w_winner  = '0;
    w_any_req = 1'b0;
    w_idx     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = (int'(r_ptr) + k) % N_REQ;
      if (bus.req[w_idx]) begin
        w_winner  = w_idx[ID_W-1:0];
        w_any_req = 1'b1;
      end
    end
  end

  assign w_grant   = (r_state == ST_IDLE) && w_any_req && !bus.eng_busy;

  // The compare uses the incremented count. The last WAIT cycle is then the
  // one ending TIMEOUT_CYCLES cycles after eng_start, so RESP lands exactly
  // TIMEOUT_CYCLES cycles after the start pulse.
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_timeout = (r_state == ST_WAIT) && (w_cnt_inc == TO_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic. eng_done takes priority over the watchdog.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_grant) w_state_nxt = ST_START;
      ST_START:   w_state_nxt = ST_WAIT;
      ST_WAIT:    if (bus.eng_done || w_timeout) w_state_nxt = ST_RESP;
      ST_RESP:    w_state_nxt = r_abort ? ST_RECOVER : ST_IDLE;
      ST_RECOVER: if (!bus.eng_busy) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: grant capture, watchdog counter and response latching.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_cur_id   <= '0;
      r_gnt      <= '0;
      r_eng_addr <= '0;
      r_rsp_id   <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_abort    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_gnt      <= {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
            r_eng_addr <= bus.req_addr[7*w_winner +: 7];
            r_cur_id   <= w_winner;
            r_ptr      <= (w_winner == ID_W'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
          end
        end
        ST_START: begin
          r_cnt   <= '0;
          r_abort <= 1'b0;
        end
        ST_WAIT: begin
          r_cnt <= w_cnt_inc;
          if (bus.eng_done) begin
            r_rsp_data <= bus.eng_data;
            r_rsp_err  <= bus.eng_nack;
            r_rsp_id   <= r_cur_id;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_rsp_id   <= r_cur_id;
            r_abort    <= 1'b1;
          end
        end
        ST_RESP: begin
          r_gnt <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.eng_start = (r_state == ST_START);
  assign bus.eng_addr  = r_eng_addr;
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_i2c_read_arbiter.sv
// Directed bench for i2c_read_arbiter. A vector table covers single-request,
// contention, wrap and NACK cases. Hand-written sequences cover the watchdog
// abort and a reset during an engine read.
`timescale 1ns/1ps
module tb_i2c_read_arbiter;

  localparam int N_REQ          = 4;
  localparam int ID_W           = 2;
  localparam int TIMEOUT_CYCLES = 20000;
  localparam int TO_W           = 16;
  localparam logic [27:0] ADDRS = {7'h4B, 7'h4A, 7'h49, 7'h48};

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         checks;
  int         failures;
  int         n_starts;
  logic [18:0] exp_q[$];

  i2c_read_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  i2c_read_arbiter #(
    .N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {bus.gnt, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err,
                 bus.eng_start, bus.eng_addr}, 32'h0);
    check({name, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- scoreboard / monitors ----------------
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected act=id%0d data=0x%0h req=none t=%0t",
                 bus.rsp_id, bus.rsp_data, $time);
      end else begin
        check("rsp_fields", {13'h0, bus.rsp_id, bus.rsp_data, bus.rsp_err}, {13'h0, exp_q.pop_front()});
      end
    end
    if (bus.eng_start === 1'b1) begin
      n_starts++;
      check("gnt_onehot", 32'($onehot(bus.gnt)), 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_start(output logic found, output int waited);
    found  = 1'b0;
    waited = -1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bus.eng_start === 1'b1) begin
        found  = 1'b1;
        waited = i;
      end
    end
  endtask

  // Serve one granted transaction with the engine model, then check the
  // response and the return to IDLE. exp_wait < 0 skips the latency check.
  task automatic serve_one(input logic [1:0] id, input logic [6:0] addr, input int delay,
                           input logic [15:0] data, input logic nack, input int exp_wait);
    logic        found;
    int          waited;
    logic [27:0] saved;
    logic [3:0]  onehot;
    onehot = 4'b0001 << id;
    wait_start(found, waited);
    check("start_seen", 32'(found), 32'd1);
    if (!found) return;
    if (exp_wait >= 0) check("grant_latency", 32'(waited), 32'(exp_wait));
    check("gnt", 32'(bus.gnt), 32'(onehot));
    check("eng_addr", 32'(bus.eng_addr), 32'(addr));
    saved = bus.req_addr;
    bus.req_addr = ~saved;
    exp_q.push_back({id, data, nack});
    @(posedge clk); #1 bus.eng_busy = 1'b1;
    repeat (delay) @(posedge clk);
    #1;
    bus.eng_done = 1'b1;
    bus.eng_data = data;
    bus.eng_nack = nack;
    bus.eng_busy = 1'b0;
    @(posedge clk); #1;
    bus.eng_done = 1'b0;
    bus.eng_data = 16'h0;
    bus.eng_nack = 1'b0;
    @(negedge clk);
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("eng_addr_hold", 32'(bus.eng_addr), 32'(addr));
    check("gnt_in_resp", 32'(bus.gnt), 32'(onehot));
    bus.req[id] = 1'b0;
    bus.req_addr = saved;
    @(negedge clk);
    check("state_idle", 32'(dbg_state), 32'd0);
    check("gnt_clear", 32'(bus.gnt), 32'd0);
    check("rsp_hold", 32'(bus.rsp_data), 32'(data));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        pre_reset;
    logic [3:0]  req_set;
    logic [27:0] addr_all;
    int          delay;
    logic [15:0] data;
    logic        nack;
    logic [1:0]  exp_id;
    logic [6:0]  exp_addr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic found;
    int   waited;
    int   k;
    int   starts0;
    logic got;

    checks = 0; failures = 0; n_starts = 0;
    rst = 1'b1;
    bus.req = '0; bus.req_addr = '0;
    bus.eng_busy = 1'b0; bus.eng_done = 1'b0; bus.eng_nack = 1'b0; bus.eng_data = '0;

    // single request; contention 0..3; serve 2 then 0101 wraps to 0; NACK
    vecs[0] = '{1'b1, 4'b0001, {21'h0, 7'h48}, 100, 16'h1980, 1'b0, 2'd0, 7'h48};
    vecs[1] = '{1'b1, 4'b1111, ADDRS, 5, 16'h00A0, 1'b0, 2'd0, 7'h48};
    vecs[2] = '{1'b0, 4'b0000, ADDRS, 7, 16'h00A1, 1'b0, 2'd1, 7'h49};
    vecs[3] = '{1'b0, 4'b0000, ADDRS, 3, 16'h00A2, 1'b0, 2'd2, 7'h4A};
    vecs[4] = '{1'b0, 4'b0000, ADDRS, 1, 16'h00A3, 1'b0, 2'd3, 7'h4B};
    vecs[5] = '{1'b0, 4'b0100, ADDRS, 4, 16'h1234, 1'b0, 2'd2, 7'h4A};
    vecs[6] = '{1'b0, 4'b0101, ADDRS, 6, 16'h5678, 1'b0, 2'd0, 7'h48};
    vecs[7] = '{1'b0, 4'b0000, ADDRS, 2, 16'h9ABC, 1'b0, 2'd2, 7'h4A};
    vecs[8] = '{1'b0, 4'b1000, ADDRS, 8, 16'hFFFF, 1'b1, 2'd3, 7'h4B};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset_state");

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].pre_reset) do_reset();
      bus.req_addr = vecs[v].addr_all;
      bus.req      = bus.req | vecs[v].req_set;
      serve_one(vecs[v].exp_id, vecs[v].exp_addr, vecs[v].delay, vecs[v].data,
                vecs[v].nack, vecs[v].pre_reset ? 1 : 0);
    end

    // ---- watchdog timeout with another request pending ----
    do_reset();
    bus.req_addr = ADDRS;
    bus.req = 4'b0001;
    wait_start(found, waited);
    check("to_start_seen", 32'(found), 32'd1);
    exp_q.push_back({2'd0, 16'h0000, 1'b1});
    @(posedge clk); #1;
    bus.eng_busy = 1'b1;
    bus.req[1] = 1'b1;
    k = 0; got = 1'b0;
    for (int i = 1; i <= TIMEOUT_CYCLES + 10 && !got; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        k = i;
      end
    end
    check("timeout_latency", 32'(k), 32'(TIMEOUT_CYCLES));
    check("timeout_err", 32'(bus.rsp_err), 32'd1);
    check("timeout_data", 32'(bus.rsp_data), 32'd0);
    bus.req[0] = 1'b0;
    starts0 = n_starts;
    @(negedge clk);
    check("state_recover", 32'(dbg_state), 32'd4);
    check("gnt_recover", 32'(bus.gnt), 32'd0);
    repeat (30000 - k - 1) @(posedge clk);
    #1;
    check("no_start_while_busy", 32'(n_starts), 32'(starts0));
    bus.eng_busy = 1'b0;
    serve_one(2'd1, 7'h49, 4, 16'h0777, 1'b0, -1);

    // ---- reset during WAIT with the engine still busy ----
    bus.req = 4'b0001;
    wait_start(found, waited);
    check("rst_start_seen", 32'(found), 32'd1);
    @(posedge clk); #1 bus.eng_busy = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bus.req = 4'b0101;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    starts0 = n_starts;
    repeat (20) @(posedge clk);
    #1;
    check("no_start_after_reset", 32'(n_starts), 32'(starts0));
    bus.eng_busy = 1'b0;
    serve_one(2'd0, 7'h48, 5, 16'hBEEF, 1'b0, -1);
    serve_one(2'd2, 7'h4A, 5, 16'hC0DE, 1'b0, 0);

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
